// File: rtl/lsu.sv
// Multi-cycle load/store unit: one aligned data-memory access per request over a
// valid/ready port, with byte-lane steering for stores and extension for loads.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_wmask,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t              r_state;
  state_t              w_next;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wmask;
  logic [31:0]         r_resp_rdata;
  logic                r_resp_err;

  logic                w_accept;
  logic                w_misaligned;
  logic [31:0]         w_lane_wdata;
  logic [3:0]          w_lane_wmask;
  logic [31:0]         w_rshift;
  logic [31:0]         w_load_ext;

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  // Illegal size is folded into the alignment error so it never reaches memory.
  always_comb begin
    unique case (i_req_size)
      SZ_BYTE: w_misaligned = 1'b0;
      SZ_HALF: w_misaligned = i_req_addr[0];
      SZ_WORD: w_misaligned = (i_req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_lane_wdata = i_req_wdata;
    w_lane_wmask = 4'b1111;
    case (i_req_size)
      SZ_BYTE: begin
        w_lane_wdata = {24'b0, i_req_wdata[7:0]} << {i_req_addr[1:0], 3'b000};
        w_lane_wmask = 4'b0001 << i_req_addr[1:0];
      end
      SZ_HALF: begin
        w_lane_wdata = {16'b0, i_req_wdata[15:0]} << {i_req_addr[1:0], 3'b000};
        w_lane_wmask = 4'b0011 << i_req_addr[1:0];
      end
      default: ;
    endcase
  end

  assign w_rshift = i_mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = i_mem_rdata;
    case (r_size)
      SZ_BYTE: w_load_ext = r_unsigned ? {24'b0, w_rshift[7:0]}
                                       : {{24{w_rshift[7]}}, w_rshift[7:0]};
      SZ_HALF: w_load_ext = r_unsigned ? {16'b0, w_rshift[15:0]}
                                       : {{16{w_rshift[15]}}, w_rshift[15:0]};
      default: ;
    endcase
  end

  // NOTE: reset is synchronous here; rst is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_misaligned ? S_RESP : S_REQ;
      S_REQ:  if (i_mem_ready) w_next = S_WAIT;
      S_WAIT: if (i_mem_rvalid) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= 4'b0000;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wen      <= i_req_wen && !w_misaligned;
        r_addr     <= i_req_addr;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_wdata    <= w_lane_wdata;
        r_wmask    <= (i_req_wen && !w_misaligned) ? w_lane_wmask : 4'b0000;
        if (w_misaligned) begin
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
        end
      end
      if ((r_state == S_WAIT) && i_mem_rvalid) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= r_wen ? 32'b0 : w_load_ext;
      end
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_valid  = (r_state == S_REQ);
  assign o_mem_wen    = r_wen;
  assign o_mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata  = r_wdata;
  assign o_mem_wmask  = r_wmask;

endmodule
